// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding, default element width and synchronizer depth for the SPI slave blocks
package spi_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOADED  = 2'b01,
    SENDING = 2'b10,
    DONE    = 2'b11
  } state_t;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spi_slave_tx_if.sv
// spi_slave_tx_if: result handshake bundle; master drives i_valid/i_results, slave drives o_ready/o_busy/o_done
interface spi_slave_tx_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int RESULT_LENGTH = 10
);
  logic                                i_valid;
  logic                                o_ready;
  logic                                o_busy;
  logic                                o_done;
  logic [RESULT_LENGTH*DATA_WIDTH-1:0] i_results;
  modport master(output i_valid, i_results, input o_ready, o_busy, o_done);
  modport slave(input i_valid, i_results, output o_ready, o_busy, o_done);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizes async din into clk (ports clk, rst_n, din -> s level, rise, fall one-cycle pulses)
module spi_sync_edge
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      d_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      d_q    <= sync_q[SYNC_STAGES-1];
    end
  end
  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~d_q;
  assign fall = ~s & d_q;
endmodule

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: latches a result vector via bus (slave modport) and shifts it MSB-first on miso per cs frame (ports clk, rst_n, sclk, cs, miso, bus)
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int RESULT_LENGTH = 10
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sclk,
  input  logic           cs,
  output logic           miso,
  spi_slave_tx_if.slave  bus
);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam int YW = $clog2(RESULT_LENGTH) + 1;
  state_t                              state_q, state_d;
  logic [RESULT_LENGTH*DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0]               sr_q;
  logic [BW-1:0]                       bit_q;
  logic [YW-1:0]                       byte_q, nxt;
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall;
  logic shift, byte_end, last, unused_ok;
  spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .din(sclk), .s(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_cs   (.clk(clk), .rst_n(rst_n), .din(cs),   .s(cs_s),   .rise(cs_rise),   .fall(cs_fall));
  assign unused_ok = sclk_s ^ sclk_rise;
  assign shift    = (state_q == SENDING) & sclk_fall & ~cs_s;
  assign byte_end = bit_q == BW'(DATA_WIDTH - 1);
  assign last     = byte_end & (byte_q == YW'(RESULT_LENGTH - 1));
  assign nxt      = byte_q + 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.i_valid ? LOADED : IDLE;
      LOADED:  state_d = cs_fall ? SENDING : LOADED;
      SENDING: state_d = cs_rise ? LOADED : (shift && last) ? DONE : SENDING;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      sr_q   <= '0;
      bit_q  <= '0;
      byte_q <= '0;
    end else if (state_q == IDLE && bus.i_valid) begin
      res_q  <= bus.i_results;
      bit_q  <= '0;
      byte_q <= '0;
    end else if (state_q == LOADED && cs_fall) begin
      sr_q <= res_q[DATA_WIDTH-1:0];
    end else if (state_q == SENDING && cs_rise) begin
      bit_q  <= '0;
      byte_q <= '0;
    end else if (shift) begin
      bit_q  <= byte_end ? '0 : bit_q + 1'b1;
      byte_q <= byte_end ? nxt : byte_q;
      sr_q   <= byte_end ? DATA_WIDTH'(res_q >> (nxt * DATA_WIDTH)) : sr_q << 1;
    end
  end
  assign bus.o_ready = state_q == IDLE;
  assign bus.o_busy  = (state_q == LOADED) | (state_q == SENDING);
  assign bus.o_done  = state_q == DONE;
  assign miso        = (state_q == SENDING) & sr_q[DATA_WIDTH-1];
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: randomized SPI-master bench for spi_slave_tx checked against a frame-level reference model
module tb_spi_slave_tx;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam int W  = DW * RL;
  logic clk = 1'b0, rst_n, sclk, cs, miso, quiet;
  logic [W-1:0] mbuf, got, v;
  int checks = 0, fails = 0, done_cnt = 0, d0, hp;
  spi_slave_tx_if #(.DATA_WIDTH(DW), .RESULT_LENGTH(RL)) bus ();
  spi_slave_tx #(.DATA_WIDTH(DW), .RESULT_LENGTH(RL)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .miso(miso), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // element 0 goes out first, each element MSB-first
  function automatic logic [W-1:0] frame_of(input logic [W-1:0] vec);
    logic [W-1:0] r = '0;
    for (int g = 0; g < RL; g++) r = (r << DW) | W'(vec[g*DW +: DW]);
    return r;
  endfunction
  always @(negedge clk) begin
    if (bus.o_done) done_cnt++;
    if (quiet) chk("miso_quiet", {31'd0, miso}, 32'd0);
  end
  task automatic load(input logic [W-1:0] val);
    int n = 0;
    while (!bus.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("load_ready", {31'd0, bus.o_ready}, 32'd1);
    bus.i_results = val;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    mbuf = val;
    chk("load_busy", {31'd0, bus.o_busy}, 32'd1);
  endtask
  task automatic frame(input int nbits, input bit live, input int h, output logic [W-1:0] res);
    if (live) quiet = 1'b0;
    cs = 1'b0;
    repeat (h) @(negedge clk);
    res = '0;
    for (int i = 0; i < nbits; i++) begin
      res = {res[W-2:0], miso};
      sclk = 1'b1;
      repeat (h) @(negedge clk);
      sclk = 1'b0;
      repeat (h) @(negedge clk);
    end
    cs = 1'b1;
    repeat (6) @(negedge clk);
    quiet = 1'b1;
    repeat (h) @(negedge clk);
  endtask
  task automatic full_check(input string nm, input int h);
    d0 = done_cnt;
    frame(W, 1'b1, h, got);
    chk({nm, "_frame"}, 32'(got), 32'(frame_of(mbuf)));
    chk({nm, "_done"}, done_cnt - d0, 32'd1);
    chk({nm, "_ready"}, {31'd0, bus.o_ready}, 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; quiet = 1'b0;
    bus.i_valid = 1'b0; bus.i_results = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.o_done}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    quiet = 1'b1;
    load(16'h3CA5);
    d0 = done_cnt;
    frame(W, 1'b1, 8, got);
    chk("basic_frame", 32'(got), 32'h0000_A53C);
    chk("basic_done", done_cnt - d0, 32'd1);
    chk("basic_ready", {31'd0, bus.o_ready}, 32'd1);
    load(16'h3CA5);
    d0 = done_cnt;
    frame(5, 1'b1, 8, got);
    chk("abort_bits", 32'(got[4:0]), 32'b10100);
    chk("abort_done", done_cnt - d0, 32'd0);
    chk("abort_busy", {31'd0, bus.o_busy}, 32'd1);
    chk("abort_ready", {31'd0, bus.o_ready}, 32'd0);
    full_check("after_abort", 8);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    load(16'h3CA5);
    frame(W, 1'b0, 8, got);
    chk("dead_frame", 32'(got), 32'd0);
    full_check("after_dead", 8);
    load(16'h3CA5);
    bus.i_results = 16'hFFFF;
    bus.i_valid = 1'b1;
    d0 = done_cnt;
    frame(W, 1'b1, 8, got);
    chk("hold_valid_frame", 32'(got), 32'h0000_A53C);
    chk("hold_valid_done", done_cnt - d0, 32'd1);
    bus.i_valid = 1'b0;
    mbuf = 16'hFFFF;
    chk("hold_valid_reload", {31'd0, bus.o_busy}, 32'd1);
    full_check("reloaded", 8);
    v = W'($urandom);
    load(v);
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
    full_check("sclk_cs_high", 8);
    load(16'h3CA5);
    quiet = 1'b0;
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_miso", {31'd0, miso}, 32'd0);
    chk("arst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("arst_ready", {31'd0, bus.o_ready}, 32'd1);
    quiet = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
    for (int i = 9; i < W; i++) begin
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    v = W'($urandom);
    load(v);
    full_check("post_reset", 8);
    for (int r = 0; r < 8; r++) begin
      v = W'($urandom);
      hp = $urandom_range(8, 12);
      load(v);
      if ($urandom_range(0, 1) == 1) begin
        d0 = done_cnt;
        frame($urandom_range(1, W - 1), 1'b1, hp, got);
        chk("rand_abort_done", done_cnt - d0, 32'd0);
      end
      full_check("rand", hp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave_tx.md
# spi_slave_tx

SPI-slave transmitter that returns the network's result vector (e.g. per-class spike counts or scores) to the external SPI master. It sits at the output end of the accelerator, mirroring the feature-input SPI slave receiver. It accepts one flat result vector via a valid/ready handshake, then shifts it out MSB-first on `miso` during the next chip-select frame. It uses the same mode-0 convention as the receiver: the master samples on SCLK rising edges, and this block changes `miso` on falling edges.

## Interface
- `DATA_WIDTH`, 8, bits per result element.
- `RESULT_LENGTH`, 10, number of elements per frame.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`.
- `cs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `miso`  out  1  serial data to master.
- `i_valid`  in  1  result vector valid.
- `o_ready`  out  1  block can accept a vector.
- `i_results`  in  RESULT_LENGTH*DATA_WIDTH  element g at bits [g*DATA_WIDTH +: DATA_WIDTH].
- `o_busy`  out  1  high in LOADED or SENDING.
- `o_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- `sclk` and `cs` each pass through a 2-flop synchronizer plus one delay flop. Edges are computed on the synchronized value: rise = s & !d, fall = !s & d.
- FSM states: IDLE, LOADED, SENDING, DONE.
  - IDLE: `o_ready`=1. If `i_valid`&&`o_ready`, all elements are latched into a result buffer, byte_idx=0, bit_idx=0 -> LOADED.
  - LOADED: `o_ready`=0. On a cs falling edge -> SENDING, and the shift register loads element 0. A cs that is already low on entry is ignored until it goes high and falls again, so the block never joins a frame mid-way.
  - SENDING: `miso` = shift_reg MSB. On each sclk falling edge: shift left by 1 and bit_idx++. When bit_idx == DATA_WIDTH-1, bit_idx=0, byte_idx++, and the shift register loads the next element. When the falling edge of the final bit (RESULT_LENGTH*DATA_WIDTH-th) occurs -> DONE.
  - DONE: `o_done`=1 for exactly one cycle, then -> IDLE.
- Abort: a cs rising edge in SENDING before the final bit -> LOADED. Counters clear and the buffer is retained, so the next frame retransmits from element 0. `o_done` does not pulse.
- sclk edges while `cs` is high, or in IDLE/LOADED, are ignored.
- A cs falling edge in IDLE is ignored, and `miso` stays 0.
- `miso` = 0 in every state except SENDING.
- Counters: bit_idx is $clog2(DATA_WIDTH)+1 bits wide, byte_idx is $clog2(RESULT_LENGTH)+1 bits wide, and neither wraps past its terminal value.
- Element bytes are sent unmodified (signed two's complement passes through bit-exact).

## Timing
- Reset values: `miso`=0, `o_busy`=0, `o_done`=0, state IDLE (`o_ready`=1), all counters, buffer and shift register = 0.
- Pin-edge to internal-edge latency is 3 `clk` cycles. `miso` updates 1 cycle after the internal edge, i.e. ≤4 `clk` cycles after the SCLK falling pin edge.
- The first bit is on `miso` ≤4 cycles after the cs falling pin edge.
- Required ratio: f_clk ≥ 8×f_sclk, and cs-low to first SCLK rise ≥ 4 clk periods.
- The handshake transfer occurs on the cycle where `i_valid`&&`o_ready` are both high. `i_results` need only be stable in that cycle.
- `o_ready` is combinational from state (IDLE only) and does not depend on `i_valid`.
- Async reset mid-frame: immediate return to reset values. The master sees `miso`=0 for the remainder of the frame.

## Structure
- Shared package `spi_pkg`: FSM state typedef/localparams (IDLE=2'b00, LOADED=2'b01, SENDING=2'b10, DONE=2'b11), the default DATA_WIDTH, and the sync stage count (2).
- Sub-module `spi_sync_edge`: 2-flop synchronizer, delay flop, rise/fall outputs. It is instantiated twice (sclk, cs) and is reusable by the receiver.
- Top level holds the FSM, result buffer, shift register and counters.

## Test plan
- RESULT_LENGTH=2, load {0x3C,0xA5} (element0=0xA5), one full frame at clk/16 -> master samples 1010_0101_0011_1100, `o_done` pulses once, `o_ready` returns to 1.
- Load, then raise cs after 5 bits -> no `o_done`, state LOADED. The next full frame reads 0xA5,0x3C from the start.
- cs low before load, data loaded mid-frame -> `miso` stays 0 that frame. The next cs fall transmits the full vector.
- `i_valid` held high during LOADED/SENDING with new data 0xFF,0xFF -> ignored, and the frame still carries 0xA5,0x3C.
- Assert rst_n low at bit 9 -> `miso`=0, `o_busy`=0, `o_ready`=1 immediately. A post-reset load and frame work normally.
- SCLK toggling with cs high while LOADED -> no shift. The first real frame starts at element0 MSB.
